// File: rtl/ula_seq_multiplier_if.sv
// Handshake and data bundle for the sequential signed multiplier.
// Requester drives start/operands; the multiplier returns status and product.
interface ula_seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 sign_flag;
  logic                 zero_flag;

  modport master (
    output start, a, b,
    input  busy, done, result, sign_flag, zero_flag
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, sign_flag, zero_flag
  );
endinterface

// File: rtl/ula_seq_multiplier.sv
// Iterative shift-and-add signed multiplier on operand magnitudes.
// One partial product per clock; sign applied in a final step.
module ula_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ula_seq_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } state_t;

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             neg;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    result_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // |x| of the minimum value wraps to itself, read back as unsigned.
  assign a_mag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.sign_flag = result_q[PW-1];
  assign bus.zero_flag = (result_q == '0);

  // Control FSM and datapath: accept, iterate WIDTH times, apply sign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      neg      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          result_q <= neg ? (~acc + PW'(1)) : acc;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq_multiplier.sv
// Self-checking bench for ula_seq_multiplier.
// Cycle model plus directed literal cases and randomized traffic.
module tb_ula_seq_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ula_seq_multiplier_if #(.WIDTH(W)) bus ();

  ula_seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: fixed latency counter and a plain signed product.
  int                 rem = 0;
  logic               m_busy = 1'b0;
  logic               m_done = 1'b0;
  logic signed [15:0] m_prod = '0;
  logic [15:0]        m_result = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = '0;
    end else begin
      m_done = 1'b0;
      if (rem == 0) begin
        if (bus.start) begin
          m_prod = $signed(bus.a) * $signed(bus.b);
          rem    = W + 1;
          m_busy = 1'b1;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_result = m_prod;
          m_done   = 1'b1;
          m_busy   = 1'b0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("result", 32'(bus.result), 32'(m_result));
    chk("sign_flag", 32'(bus.sign_flag), 32'(m_result[15]));
    chk("zero_flag", 32'(bus.zero_flag), 32'(m_result == 16'h0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) begin
      chk("done_timeout", 32'(n), 32'd9);
    end
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y,
                    input logic [15:0] exp, input string nm);
    int n;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({nm, "_busy_e0"}, 32'(bus.busy), 32'd1);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'd9);
    chk({nm, "_result"}, 32'(bus.result), 32'(exp));
    chk({nm, "_sign"}, 32'(bus.sign_flag), 32'(exp[15]));
    chk({nm, "_zero"}, 32'(bus.zero_flag), 32'(exp == 16'h0));
    tick();
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] v;
    case ($urandom_range(0, 6))
      0: v = 8'h80;
      1: v = 8'h7F;
      2: v = 8'h00;
      3: v = 8'hFF;
      4: v = 8'h01;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int n;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_zero", 32'(bus.zero_flag), 32'd1);
    reset = 1'b0;
    tick();

    op(8'd7, 8'd6, 16'h002A, "pos");
    op(8'hFB, 8'd3, 16'hFFF1, "neg5x3");
    op(8'h80, 8'h80, 16'h4000, "min_min");
    op(8'h80, 8'h7F, 16'hC080, "min_max");
    op(8'h00, 8'hB3, 16'h0000, "zero");

    // Start while busy and operand churn are ignored.
    bus.a = 8'd3;
    bus.b = 8'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.a = 8'd9;
    bus.b = 8'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = 8'h55;
    bus.b = 8'hAA;
    wait_done(n);
    chk("busy_start_lat", 32'(n), 32'd5);
    chk("busy_start_res", 32'(bus.result), 32'h000C);
    tick();
    chk("busy_start_quiet", 32'(bus.busy), 32'd0);
    tick();

    // Reset in the middle of a run.
    bus.a = 8'd10;
    bus.b = 8'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_zero", 32'(bus.zero_flag), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    op(8'd2, 8'd2, 16'h0004, "after_rst");

    // Back-to-back with start held high.
    bus.a = 8'd5;
    bus.b = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.a = 8'hFE;
    bus.b = 8'd8;
    wait_done(n);
    chk("b2b_lat1", 32'(n), 32'd9);
    chk("b2b_res1", 32'(bus.result), 32'h0019);
    tick();
    bus.start = 1'b0;
    chk("b2b_accept", 32'(bus.busy), 32'd1);
    wait_done(n);
    chk("b2b_lat2", 32'(n), 32'd9);
    chk("b2b_res2", 32'(bus.result), 32'hFFF0);
    tick();

    // Randomized traffic against the model.
    repeat (3000) begin
      bus.a = pick();
      bus.b = pick();
      bus.start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
